// File: rtl/udl_mod_counter.sv
// udl_mod_counter: up/down/load counter with a run-time modulus (range 0..max_val).
// Wraps or saturates at the limits, flags terminal count combinationally and
// pulses wrap_pulse for one cycle after each wrapping step.
// Optional feature macro: UDL_CNT_PRESCALE_EN (inserts a PRESCALE-cycle step prescaler).
module udl_mod_counter #(
    parameter int unsigned BITS     = 4,
    parameter int unsigned PRESCALE = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            up,
    input  logic            load,
    input  logic [BITS-1:0] D,
    input  logic [BITS-1:0] max_val,
    input  logic            sat_mode,
    output logic [BITS-1:0] Q,
    output logic            tc,
    output logic            wrap_pulse
);

    logic [BITS-1:0] q_d, q_q;
    logic            wrap_d, wrap_q;
    logic            step_en;

`ifdef UDL_CNT_PRESCALE_EN
    localparam int unsigned PcntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PcntW-1:0] PcntLast = PcntW'(PRESCALE - 1);

    logic [PcntW-1:0] pcnt_d, pcnt_q;
    logic             tick;

    assign tick = enable & (pcnt_q == PcntLast);

    // Prescaler: cycles through enabled clocks, restarts its period on load
    always_comb begin
        pcnt_d = pcnt_q;
        if (load) begin
            pcnt_d = '0;
        end else if (enable) begin
            pcnt_d = (pcnt_q == PcntLast) ? '0 : pcnt_q + 1'b1;
        end
    end

    // Prescaler register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign step_en = tick & ~load;
`else
    // Keeps the prescale parameter referenced when the prescaler is compiled out
    logic unused_prescale;
    assign unused_prescale = ^PRESCALE;

    assign step_en = enable & ~load;
`endif

    // Next count and wrap flag; Q above max_val (max_val lowered) counts as at the limit
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        if (load) begin
            q_d = (D > max_val) ? max_val : D;
        end else if (step_en) begin
            if (up) begin
                if (q_q >= max_val) begin
                    if (sat_mode) begin
                        q_d = max_val;
                    end else begin
                        q_d    = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    q_d = q_q + 1'b1;
                end
            end else begin
                if (q_q > max_val) begin
                    q_d = max_val;
                end else if (q_q == '0) begin
                    if (!sat_mode) begin
                        q_d    = max_val;
                        wrap_d = 1'b1;
                    end
                end else begin
                    q_d = q_q - 1'b1;
                end
            end
        end
    end

    // Count and wrap pulse registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign Q          = q_q;
    assign wrap_pulse = wrap_q;
    assign tc         = step_en & ((up & (q_q >= max_val)) | (~up & (q_q == '0)));

endmodule

// File: tb/tb_udl_mod_counter.sv
// Directed self-checking bench for udl_mod_counter (BITS=4, PRESCALE=4).
module tb_udl_mod_counter;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       up;
    logic       load;
    logic [3:0] D;
    logic [3:0] max_val;
    logic       sat_mode;
    logic [3:0] Q;
    logic       tc;
    logic       wrap_pulse;

    int total;
    int bad;

    udl_mod_counter #(
        .BITS    (4),
        .PRESCALE(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .up        (up),
        .load      (load),
        .D         (D),
        .max_val   (max_val),
        .sat_mode  (sat_mode),
        .Q         (Q),
        .tc        (tc),
        .wrap_pulse(wrap_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle away from it
    task automatic tick_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] val);
        load = 1'b1;
        D    = val;
        tick_clk();
        load = 1'b0;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        enable   = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        D        = 4'd0;
        max_val  = 4'd9;
        sat_mode = 1'b0;
        #12;
        total++;
        if (Q !== 4'd0) begin
            bad++;
            $display("FAIL reset_q: got %0d want 0", Q);
        end
        total++;
        if (wrap_pulse !== 1'b0) begin
            bad++;
            $display("FAIL reset_wrap: got %b want 0", wrap_pulse);
        end
        tick_clk();
        reset_n = 1'b1;
        tick_clk();
        total++;
        if (Q !== 4'd0) begin
            bad++;
            $display("FAIL reset_release_hold: got %0d want 0", Q);
        end
    endtask

    task automatic test_wrap_up();
        logic [3:0] e;
        max_val  = 4'd9;
        sat_mode = 1'b0;
        up       = 1'b1;
        enable   = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            total++;
            if (tc !== (((i - 1) % 10) == 9)) begin
                bad++;
                $display("FAIL wrap_up_tc[%0d]: got %b want %b", i, tc, (((i - 1) % 10) == 9));
            end
            tick_clk();
            e = 4'(i % 10);
            total++;
            if (Q !== e) begin
                bad++;
                $display("FAIL wrap_up_q[%0d]: got %0d want %0d", i, Q, e);
            end
            total++;
            if (wrap_pulse !== (i == 10)) begin
                bad++;
                $display("FAIL wrap_up_pulse[%0d]: got %b want %b", i, wrap_pulse, (i == 10));
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_sat_down();
        logic [3:0] exp_q [4];
        exp_q = '{4'd1, 4'd0, 4'd0, 4'd0};
        max_val  = 4'd9;
        sat_mode = 1'b1;
        up       = 1'b0;
        do_load(4'd2);
        total++;
        if (Q !== 4'd2) begin
            bad++;
            $display("FAIL sat_down_load: got %0d want 2", Q);
        end
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (tc !== (i >= 2)) begin
                bad++;
                $display("FAIL sat_down_tc[%0d]: got %b want %b", i, tc, (i >= 2));
            end
            tick_clk();
            total++;
            if (Q !== exp_q[i] || wrap_pulse !== 1'b0) begin
                bad++;
                $display("FAIL sat_down_q[%0d]: got q=%0d wp=%b want q=%0d wp=0",
                         i, Q, wrap_pulse, exp_q[i]);
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_load_clamp();
        // Q is 0 counting down: tc must still be low while load is asserted
        max_val  = 4'd9;
        sat_mode = 1'b0;
        up       = 1'b0;
        enable   = 1'b1;
        load     = 1'b1;
        D        = 4'd13;
        #1;
        total++;
        if (tc !== 1'b0) begin
            bad++;
            $display("FAIL load_tc_low: got %b want 0", tc);
        end
        tick_clk();
        load = 1'b0;
        total++;
        if (Q !== 4'd9 || wrap_pulse !== 1'b0) begin
            bad++;
            $display("FAIL load_clamp: got q=%0d wp=%b want q=9 wp=0", Q, wrap_pulse);
        end
        enable = 1'b0;
        do_load(4'd3);
        total++;
        if (Q !== 4'd3) begin
            bad++;
            $display("FAIL load_no_enable: got %0d want 3", Q);
        end
        tick_clk();
        total++;
        if (Q !== 4'd3 || wrap_pulse !== 1'b0) begin
            bad++;
            $display("FAIL hold_disabled: got q=%0d wp=%b want q=3 wp=0", Q, wrap_pulse);
        end
    endtask

    task automatic test_lowered_max();
        sat_mode = 1'b0;
        enable   = 1'b0;
        max_val  = 4'd15;
        do_load(4'd7);
        max_val = 4'd4;
        up      = 1'b1;
        enable  = 1'b1;
        #1;
        total++;
        if (tc !== 1'b1) begin
            bad++;
            $display("FAIL lowered_up_tc: got %b want 1", tc);
        end
        tick_clk();
        total++;
        if (Q !== 4'd0 || wrap_pulse !== 1'b1) begin
            bad++;
            $display("FAIL lowered_up: got q=%0d wp=%b want q=0 wp=1", Q, wrap_pulse);
        end
        enable  = 1'b0;
        max_val = 4'd15;
        do_load(4'd7);
        max_val = 4'd4;
        up      = 1'b0;
        enable  = 1'b1;
        tick_clk();
        total++;
        if (Q !== 4'd4 || wrap_pulse !== 1'b0) begin
            bad++;
            $display("FAIL lowered_down: got q=%0d wp=%b want q=4 wp=0", Q, wrap_pulse);
        end
        enable = 1'b0;
    endtask

    task automatic test_async_reset();
        max_val  = 4'd15;
        sat_mode = 1'b0;
        up       = 1'b1;
        do_load(4'd5);
        enable = 1'b1;
        tick_clk();
        total++;
        if (Q !== 4'd6) begin
            bad++;
            $display("FAIL areset_setup: got %0d want 6", Q);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (Q !== 4'd0 || wrap_pulse !== 1'b0) begin
            bad++;
            $display("FAIL areset_immediate: got q=%0d wp=%b want q=0 wp=0", Q, wrap_pulse);
        end
        tick_clk();
        total++;
        if (Q !== 4'd0) begin
            bad++;
            $display("FAIL areset_held: got %0d want 0", Q);
        end
        #2;
        reset_n = 1'b1;
        tick_clk();
        total++;
        if (Q !== 4'd1) begin
            bad++;
            $display("FAIL areset_restart1: got %0d want 1", Q);
        end
        tick_clk();
        total++;
        if (Q !== 4'd2) begin
            bad++;
            $display("FAIL areset_restart2: got %0d want 2", Q);
        end
        enable = 1'b0;
    endtask

    task automatic test_boundaries();
        // max_val = 0 in wrap mode: every step is a wrap, so pulses are back to back
        max_val  = 4'd15;
        do_load(4'd0);
        max_val  = 4'd0;
        sat_mode = 1'b0;
        up       = 1'b1;
        enable   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick_clk();
            total++;
            if (Q !== 4'd0 || wrap_pulse !== 1'b1) begin
                bad++;
                $display("FAIL max0_wrap[%0d]: got q=%0d wp=%b want q=0 wp=1", i, Q, wrap_pulse);
            end
        end
        sat_mode = 1'b1;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (tc !== 1'b1) begin
                bad++;
                $display("FAIL max0_sat_tc[%0d]: got %b want 1", i, tc);
            end
            tick_clk();
            total++;
            if (Q !== 4'd0 || wrap_pulse !== 1'b0) begin
                bad++;
                $display("FAIL max0_sat[%0d]: got q=%0d wp=%b want q=0 wp=0", i, Q, wrap_pulse);
            end
        end
        // Full-range modulus: plain binary wrap 15 -> 0 and down 0 -> 15
        enable   = 1'b0;
        sat_mode = 1'b0;
        max_val  = 4'd15;
        do_load(4'd15);
        enable = 1'b1;
        tick_clk();
        total++;
        if (Q !== 4'd0 || wrap_pulse !== 1'b1) begin
            bad++;
            $display("FAIL full_up_wrap: got q=%0d wp=%b want q=0 wp=1", Q, wrap_pulse);
        end
        up = 1'b0;
        tick_clk();
        total++;
        if (Q !== 4'd15 || wrap_pulse !== 1'b1) begin
            bad++;
            $display("FAIL full_down_wrap: got q=%0d wp=%b want q=15 wp=1", Q, wrap_pulse);
        end
        tick_clk();
        total++;
        if (Q !== 4'd14 || wrap_pulse !== 1'b0) begin
            bad++;
            $display("FAIL full_down_step: got q=%0d wp=%b want q=14 wp=0", Q, wrap_pulse);
        end
        enable = 1'b0;
    endtask

`ifdef UDL_CNT_PRESCALE_EN
    task automatic test_prescale();
        reset_n = 1'b0;
        #3;
        reset_n  = 1'b1;
        max_val  = 4'd15;
        sat_mode = 1'b0;
        up       = 1'b1;
        enable   = 1'b1;
        for (int i = 0; i < 16; i++) tick_clk();
        total++;
        if (Q !== 4'd4) begin
            bad++;
            $display("FAIL prescale_16: got %0d want 4", Q);
        end
        // two enabled cycles, three idle, one enabled: pcnt reaches 3 without stepping
        tick_clk();
        tick_clk();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) tick_clk();
        enable = 1'b1;
        tick_clk();
        total++;
        if (Q !== 4'd4) begin
            bad++;
            $display("FAIL prescale_hold: got %0d want 4", Q);
        end
        tick_clk();
        total++;
        if (Q !== 4'd5) begin
            bad++;
            $display("FAIL prescale_resume: got %0d want 5", Q);
        end
        tick_clk();
        tick_clk();
        do_load(4'd0);
        for (int i = 0; i < 3; i++) tick_clk();
        total++;
        if (Q !== 4'd0) begin
            bad++;
            $display("FAIL prescale_load_restart: got %0d want 0", Q);
        end
        tick_clk();
        total++;
        if (Q !== 4'd1) begin
            bad++;
            $display("FAIL prescale_after_load: got %0d want 1", Q);
        end
        enable = 1'b0;
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_load_clamp();
        test_lowered_max();
        test_async_reset();
        test_boundaries();
`ifdef UDL_CNT_PRESCALE_EN
        test_prescale();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
